// File: rtl/sp_ram_bwe.sv
// Single-port synchronous RAM with byte write enables, configurable read pipeline,
// out-of-range protection and an optional post-reset clear sequencer.
module sp_ram_bwe #(
    parameter int                     AW             = 3,
    parameter int                     DEPTH          = 2**AW,
    parameter int                     NB             = 1,
    parameter int                     BW             = 8,
    parameter int                     READ_LATENCY_A = 1,
    parameter string                  WRITE_MODE_A   = "read_first",
    parameter logic [NB*BW-1:0]       RST_VAL        = {(NB*BW){1'b0}},
    parameter bit                     CLEAR_ON_RESET = 1'b0
) (
    input  logic                      clka,
    input  logic                      rsta,
    input  logic                      ena,
    input  logic [NB-1:0]             wea,
    input  logic [AW-1:0]             addra,
    input  logic [NB*BW-1:0]          dina,
    input  logic                      regcea,
    output logic [NB*BW-1:0]          douta,
    output logic                      douta_vld,
    output logic                      init_busy
);

    localparam int             DW        = NB * BW;
    localparam int             L         = READ_LATENCY_A;
    localparam bit             WF        = (WRITE_MODE_A == "write_first");
    localparam bit             NO_CHANGE = (WRITE_MODE_A == "no_change");
    localparam logic [AW:0]    DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t            state_r;
    logic [AW-1:0]         clr_addr_r;
    logic                  init_busy_r;

    logic [DW-1:0]         mem [DEPTH];

    logic                  acc_s;
    logic                  in_range_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [DW-1:0]         old_s;
    logic [DW-1:0]         merged_s;
    logic [DW-1:0]         rd_data_s;

    logic [L-1:0]          pipe_vld_r;
    logic [L-1:0][DW-1:0]  pipe_data_r;
    logic [L-1:0]          stg_vld_s;
    logic [L-1:0][DW-1:0]  stg_data_s;

    // Port access decode and read-word selection (out-of-range reads yield zero)
    always_comb begin
        acc_s      = ena && !init_busy_r;
        in_range_s = ({1'b0, addra} < DEPTH_W);
        wr_s       = acc_s && (|wea) && in_range_s;
        rd_s       = acc_s && !(NO_CHANGE && (|wea));
        if (in_range_s) begin
            old_s = mem[addra];
        end else begin
            old_s = {DW{1'b0}};
        end
        merged_s = old_s;
        for (int i = 0; i < NB; i++) begin
            if (wea[i]) begin
                merged_s[i*BW +: BW] = dina[i*BW +: BW];
            end else begin
                merged_s[i*BW +: BW] = old_s[i*BW +: BW];
            end
        end
        if (WF && in_range_s) begin
            rd_data_s = merged_s;
        end else begin
            rd_data_s = old_s;
        end
    end

    // Memory array: the clear sequencer owns the write port while busy
    always_ff @(posedge clka) begin
        if ((state_r == ST_CLEAR) && !rsta) begin
            mem[clr_addr_r] <= {DW{1'b0}};
        end else if (wr_s) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    mem[addra][i*BW +: BW] <= dina[i*BW +: BW];
                end
            end
        end
    end

    // Clear sequencer; a reset while clearing restarts from address zero
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_r     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_addr_r  <= {AW{1'b0}};
            init_busy_r <= CLEAR_ON_RESET;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    init_busy_r <= 1'b0;
                end
                ST_CLEAR: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r     <= ST_IDLE;
                        clr_addr_r  <= {AW{1'b0}};
                        init_busy_r <= 1'b0;
                    end else begin
                        clr_addr_r  <= clr_addr_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    clr_addr_r  <= {AW{1'b0}};
                    init_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Input of every pipeline stage: stage 0 takes the RAM read, others the previous stage
    always_comb begin
        stg_vld_s  = {L{1'b0}};
        stg_data_s = {L{{DW{1'b0}}}};
        stg_vld_s[0]  = rd_s;
        stg_data_s[0] = rd_data_s;
        for (int i = 1; i < L; i++) begin
            stg_vld_s[i]  = pipe_vld_r[i-1];
            stg_data_s[i] = pipe_data_r[i-1];
        end
    end

    // Read pipeline: bubbles clear valid but keep data; the last stage is gated by regcea
    always_ff @(posedge clka) begin
        if (rsta) begin
            pipe_vld_r  <= {L{1'b0}};
            pipe_data_r <= {L{RST_VAL}};
        end else begin
            for (int i = 0; i < L; i++) begin
                if ((i < L - 1) || (L == 1) || regcea) begin
                    pipe_vld_r[i] <= stg_vld_s[i];
                    if (stg_vld_s[i]) begin
                        pipe_data_r[i] <= stg_data_s[i];
                    end
                end
            end
        end
    end

    assign douta     = pipe_data_r[L-1];
    assign douta_vld = pipe_vld_r[L-1];
    assign init_busy = init_busy_r;

endmodule

// File: tb/tb_sp_ram_bwe.sv
// Scoreboard bench for sp_ram_bwe: four instances in different modes, expected reads queued
// at issue time and popped by per-instance monitors whenever a new result is presented.
module tb_sp_ram_bwe;

    localparam int N = 4;
    localparam int LAT [N] = '{3, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rsta      [N];
    logic       ena       [N];
    logic [1:0] wea       [N];
    logic [2:0] addra     [N];
    logic [7:0] dina      [N];
    logic       regcea    [N];
    logic [7:0] douta     [N];
    logic       douta_vld [N];
    logic       init_busy [N];

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    sp_ram_bwe #(.AW(3), .DEPTH(6), .NB(2), .BW(4), .READ_LATENCY_A(3), .WRITE_MODE_A("read_first"),
                 .RST_VAL(8'h00), .CLEAR_ON_RESET(1'b1)) u0 (
        .clka(clk), .rsta(rsta[0]), .ena(ena[0]), .wea(wea[0]), .addra(addra[0]), .dina(dina[0]),
        .regcea(regcea[0]), .douta(douta[0]), .douta_vld(douta_vld[0]), .init_busy(init_busy[0]));

    sp_ram_bwe #(.AW(3), .DEPTH(6), .NB(2), .BW(4), .READ_LATENCY_A(1), .WRITE_MODE_A("write_first"),
                 .RST_VAL(8'h5A), .CLEAR_ON_RESET(1'b0)) u1 (
        .clka(clk), .rsta(rsta[1]), .ena(ena[1]), .wea(wea[1]), .addra(addra[1]), .dina(dina[1]),
        .regcea(regcea[1]), .douta(douta[1]), .douta_vld(douta_vld[1]), .init_busy(init_busy[1]));

    sp_ram_bwe #(.AW(3), .DEPTH(6), .NB(2), .BW(4), .READ_LATENCY_A(2), .WRITE_MODE_A("no_change"),
                 .RST_VAL(8'h00), .CLEAR_ON_RESET(1'b0)) u2 (
        .clka(clk), .rsta(rsta[2]), .ena(ena[2]), .wea(wea[2]), .addra(addra[2]), .dina(dina[2]),
        .regcea(regcea[2]), .douta(douta[2]), .douta_vld(douta_vld[2]), .init_busy(init_busy[2]));

    sp_ram_bwe #(.AW(3), .DEPTH(6), .NB(2), .BW(4), .READ_LATENCY_A(1), .WRITE_MODE_A("read_first"),
                 .RST_VAL(8'h00), .CLEAR_ON_RESET(1'b1)) u3 (
        .clka(clk), .rsta(rsta[3]), .ena(ena[3]), .wea(wea[3]), .addra(addra[3]), .dina(dina[3]),
        .regcea(regcea[3]), .douta(douta[3]), .douta_vld(douta_vld[3]), .init_busy(init_busy[3]));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A new result is presented after every edge where the last stage was enabled and valid is set
    for (genvar g = 0; g < N; g++) begin : mon
        logic [7:0] q [$];
        logic       rce;
        logic [7:0] exp_v;
        always begin
            @(posedge clk);
            rce = regcea[g] || (LAT[g] == 1);
            #1;
            if (rce && douta_vld[g] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL u%0d unexpected read: got %h, expected no valid", g, douta[g]);
                end else begin
                    exp_v = q.pop_front();
                    if (douta[g] !== exp_v) begin
                        errors++;
                        $display("FAIL u%0d read: got %h, expected %h", g, douta[g], exp_v);
                    end
                end
            end
        end
    end

    task automatic push(input int k, input logic [7:0] v);
        case (k)
            0: mon[0].q.push_back(v);
            1: mon[1].q.push_back(v);
            2: mon[2].q.push_back(v);
            3: mon[3].q.push_back(v);
            default: ;
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return mon[0].q.size();
            1: return mon[1].q.size();
            2: return mon[2].q.size();
            3: return mon[3].q.size();
            default: return 0;
        endcase
    endfunction

    task automatic cyc(input int k, input logic rst, input logic en, input logic [1:0] we,
                       input logic [2:0] a, input logic [7:0] d, input logic rce,
                       input logic exp_rd, input logic [7:0] ev);
        rsta[k] = rst; ena[k] = en; wea[k] = we; addra[k] = a; dina[k] = d; regcea[k] = rce;
        if (exp_rd) push(k, ev);
        @(posedge clk);
        #1;
        rsta[k] = 1'b0; ena[k] = 1'b0; wea[k] = 2'b00; regcea[k] = 1'b1;
    endtask

    task automatic idle(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) cyc(k, 1'b0, 1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    endtask

    // Counts samples with init_busy high, issuing the given access on every busy cycle
    task automatic busy_count(input int k, input logic en, input logic [1:0] we,
                              input logic [2:0] a, input logic [7:0] d, output int cnt);
        cnt = 0;
        while (init_busy[k] && cnt < 20) begin
            cnt++;
            cyc(k, 1'b0, en, we, a, d, 1'b1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            rsta[k] = 1'b1; ena[k] = 1'b0; wea[k] = 2'b00; addra[k] = 3'd0; dina[k] = 8'h00; regcea[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("u0 reset douta", douta[0], 8'h00);
        chk("u1 reset douta", douta[1], 8'h5A);
        chk("u2 reset douta", douta[2], 8'h00);
        chk("u3 reset douta", douta[3], 8'h00);
        for (int k = 0; k < N; k++) chk($sformatf("u%0d reset vld", k), {7'd0, douta_vld[k]}, 8'h00);
        chk("u0 reset busy", {7'd0, init_busy[0]}, 8'h01);
        chk("u1 reset busy", {7'd0, init_busy[1]}, 8'h00);
        chk("u2 reset busy", {7'd0, init_busy[2]}, 8'h00);
        chk("u3 reset busy", {7'd0, init_busy[3]}, 8'h01);
        for (int k = 0; k < N; k++) rsta[k] = 1'b0;

        // Clear takes DEPTH cycles; all in-range words read back zero, out-of-range reads zero
        busy_count(0, 1'b0, 2'b00, 3'd0, 8'h00, n);
        chk("u0 clear busy cycles", 8'(n), 8'd6);
        for (int a = 0; a < 7; a++) cyc(0, 1'b0, 1'b1, 2'b00, 3'(a), 8'h00, 1'b1, 1'b1, 8'h00);
        idle(0, 3);

        // Byte-lane merge, read_first returns pre-write words
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd2, 8'hA5, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b01, 3'd2, 8'h3C, 1'b1, 1'b1, 8'hA5);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd2, 8'h00, 1'b1, 1'b1, 8'hAC);
        idle(0, 3);

        // regcea low for two edges: the two reads passing stage 2 then are dropped
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd0, 8'h10, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd1, 8'h21, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd3, 8'h43, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd4, 8'h54, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd5, 8'h65, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd0, 8'h00, 1'b1, 1'b1, 8'h10);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 8'h21);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd2, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd4, 8'h00, 1'b0, 1'b1, 8'h54);
        chk("u0 frozen douta 1", douta[0], 8'h21);
        chk("u0 frozen vld 1", {7'd0, douta_vld[0]}, 8'h01);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd5, 8'h00, 1'b0, 1'b1, 8'h65);
        chk("u0 frozen douta 2", douta[0], 8'h21);
        chk("u0 frozen vld 2", {7'd0, douta_vld[0]}, 8'h01);
        idle(0, 4);

        // Reset during clear at clr_addr 3 restarts it; accesses while busy are ignored
        cyc(0, 1'b1, 1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00);
        idle(0, 3);
        cyc(0, 1'b1, 1'b1, 2'b11, 3'd7, 8'hEE, 1'b1, 1'b0, 8'h00);
        busy_count(0, 1'b1, 2'b11, 3'd7, 8'hEE, n);
        chk("u0 restart busy cycles", 8'(n), 8'd6);
        cyc(0, 1'b0, 1'b1, 2'b11, 3'd7, 8'hEE, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd7, 8'h00, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd6, 8'h00, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd2, 8'h00, 1'b1, 1'b1, 8'h00);
        cyc(0, 1'b0, 1'b1, 2'b00, 3'd4, 8'h00, 1'b1, 1'b1, 8'h00);
        idle(0, 4);

        // write_first, latency 1: merged word is visible right after the write edge
        cyc(1, 1'b0, 1'b1, 2'b11, 3'd4, 8'h11, 1'b1, 1'b1, 8'h11);
        cyc(1, 1'b0, 1'b1, 2'b11, 3'd4, 8'h77, 1'b1, 1'b1, 8'h77);
        chk("u1 write_first douta", douta[1], 8'h77);
        cyc(1, 1'b0, 1'b1, 2'b01, 3'd4, 8'h0B, 1'b1, 1'b1, 8'h7B);
        cyc(1, 1'b0, 1'b1, 2'b00, 3'd4, 8'h00, 1'b1, 1'b1, 8'h7B);
        idle(1, 1);
        chk("u1 bubble douta held", douta[1], 8'h7B);
        chk("u1 bubble vld", {7'd0, douta_vld[1]}, 8'h00);

        // read_first, latency 1, regcea held low (ignored): old word after the write edge
        chk("u3 clear done", {7'd0, init_busy[3]}, 8'h00);
        cyc(3, 1'b0, 1'b1, 2'b11, 3'd4, 8'h11, 1'b0, 1'b1, 8'h00);
        cyc(3, 1'b0, 1'b1, 2'b11, 3'd4, 8'h77, 1'b0, 1'b1, 8'h11);
        chk("u3 read_first douta", douta[3], 8'h11);
        cyc(3, 1'b0, 1'b1, 2'b00, 3'd4, 8'h00, 1'b0, 1'b1, 8'h77);
        idle(3, 2);

        // no_change, latency 2: write cycles issue no read and leave douta untouched
        cyc(2, 1'b0, 1'b1, 2'b11, 3'd1, 8'h12, 1'b1, 1'b0, 8'h00);
        cyc(2, 1'b0, 1'b1, 2'b11, 3'd3, 8'h34, 1'b1, 1'b0, 8'h00);
        cyc(2, 1'b0, 1'b1, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 8'h12);
        cyc(2, 1'b0, 1'b1, 2'b00, 3'd3, 8'h00, 1'b1, 1'b1, 8'h34);
        cyc(2, 1'b0, 1'b1, 2'b11, 3'd1, 8'h56, 1'b1, 1'b0, 8'h00);
        idle(2, 1);
        chk("u2 no_change douta held", douta[2], 8'h34);
        chk("u2 no_change vld", {7'd0, douta_vld[2]}, 8'h00);
        cyc(2, 1'b0, 1'b1, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 8'h56);
        idle(2, 3);

        for (int k = 0; k < N; k++) chk($sformatf("u%0d pending reads", k), 8'(qsize(k)), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
